pb_debounce_divider: RTL and testbench

Pushbutton conditioning block with two independent datapaths that share one clock, one reset and one enable.
- A free-running binary up counter whose bits serve as divided clocks (clk/2, clk/4, clk/8 for the default width).
- A serial-in/serial-out shift register that delays, and optionally debounces, a raw pushbutton input.
The block sits between the board pushbutton pin and the synchronous control logic.

---
 rtl/pb_debounce_divider.sv | 57 +++++
 tb/tb_pb_debounce_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_divider.sv
// Pushbutton conditioning: free-running clock divider plus a delay/debounce shift chain.
// Optional macro PB_DEBOUNCE_EN turns the plain delay line into a DEPTH-sample debouncer.
module pb_debounce_divider #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             entrada,
    output logic [CNT_W-1:0] q,
    output logic             salida
);

    logic [DEPTH-1:0] stages;
    logic [DEPTH-1:0] stages_next;

    // Each bit of q toggles at half the rate of the bit below it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= q + CNT_W'(1);
        end
    end

    // stages[0] is the only flop that samples the asynchronous button pin.
    always_comb begin
        stages_next = {stages[DEPTH-2:0], entrada};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else if (enable) begin
            stages <= stages_next;
        end
    end

`ifdef PB_DEBOUNCE_EN
    // Output follows only once the whole window agrees, so short bounces are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            salida <= 1'b0;
        end else if (enable) begin
            if (&stages_next) begin
                salida <= 1'b1;
            end else if (~|stages_next) begin
                salida <= 1'b0;
            end
        end
    end
`else
    assign salida = stages[DEPTH-1];
`endif

endmodule

// File: tb/tb_pb_debounce_divider.sv
// Directed self-checking bench for pb_debounce_divider (default widths CNT_W=3, DEPTH=4).
// Expected salida values depend on whether PB_DEBOUNCE_EN is defined.
module tb_pb_debounce_divider;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       entrada;
    logic [2:0] q;
    logic       salida;

    int vector_count;
    int miscompare_count;
    int exp_q;

    pb_debounce_divider #(.CNT_W(3), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .entrada (entrada),
        .q       (q),
        .salida  (salida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive inputs away from the edge, then advance one rising edge and settle.
    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic in_v);
        reset   = rst_v;
        enable  = en_v;
        entrada = in_v;
        @(posedge clk);
        #1;
    endtask

    logic bounce_in  [10];
    logic bounce_exp [10];

    initial begin
        vector_count     = 0;
        miscompare_count = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        entrada = 1'b1;
        #1;
        checkOutput("reset_q_initial", 32'(q), 32'd0);
        checkOutput("reset_salida_initial", 32'(salida), 32'd0);

        $display("[TB] reset dominates enable and clock");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("reset_q", 32'(q), 32'd0);
            checkOutput("reset_salida", 32'(salida), 32'd0);
        end

        $display("[TB] reset released, enable low");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("hold_q", 32'(q), 32'd0);
            checkOutput("hold_salida", 32'(salida), 32'd0);
        end

        $display("[TB] count, wrap and rising latency");
        exp_q = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            exp_q = (exp_q + 1) % 8;
            checkOutput("count_q", 32'(q), 32'(exp_q));
            checkOutput("rise_latency", 32'(salida), (i >= 4) ? 32'd1 : 32'd0);
        end

        $display("[TB] falling latency");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            exp_q = (exp_q + 1) % 8;
            checkOutput("fall_q", 32'(q), 32'(exp_q));
            checkOutput("fall_latency", 32'(salida), (i >= 4) ? 32'd0 : 32'd1);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            exp_q = (exp_q + 1) % 8;
        end
        checkOutput("pre_bounce_salida", 32'(salida), 32'd1);

        $display("[TB] bounce from 1 down to 0");
        bounce_in = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef PB_DEBOUNCE_EN
        bounce_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        bounce_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, bounce_in[i]);
            exp_q = (exp_q + 1) % 8;
            checkOutput("bounce_down_salida", 32'(salida), 32'(bounce_exp[i]));
            checkOutput("bounce_down_q", 32'(q), 32'(exp_q));
        end

        $display("[TB] bounce from 0 up to 1");
        bounce_in = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef PB_DEBOUNCE_EN
        bounce_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        bounce_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, bounce_in[i]);
            checkOutput("bounce_up_salida", 32'(salida), 32'(bounce_exp[i]));
        end

        $display("[TB] asynchronous reset between edges");
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("async_pre_q", 32'(q), 32'd5);
        checkOutput("async_pre_salida", 32'(salida), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_q_cleared", 32'(q), 32'd0);
        checkOutput("async_salida_cleared", 32'(salida), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("async_post_q", 32'(q), 32'd1);
        checkOutput("async_post_salida", 32'(salida), 32'd0);

        $display("[TB] enable gating with partly filled chain");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("gate_fill_q", 32'(q), 32'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("gate_frozen_q", 32'(q), 32'd2);
            checkOutput("gate_frozen_salida", 32'(salida), 32'd0);
        end
`ifdef PB_DEBOUNCE_EN
        bounce_exp[0:3] = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        bounce_exp[0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("gate_resume_q", 32'(q), 32'(3 + i));
            checkOutput("gate_resume_salida", 32'(salida), 32'(bounce_exp[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
